// File: rtl/cache_control_pkg.sv
// Shared types and constants for the L1 cache control FSM.
package cache_control_pkg;

    typedef enum logic [1:0] {
        CC_IDLE      = 2'd0,
        CC_WRITEBACK = 2'd1,
        CC_ALLOCATE  = 2'd2
    } cache_ctrl_state_e;

    typedef logic cache_way_t;

    localparam cache_way_t WAY0      = 1'b0;
    localparam cache_way_t WAY1      = 1'b1;
    localparam logic       DSRC_CPU  = 1'b0;
    localparam logic       DSRC_PMEM = 1'b1;

    // One-hot array write strobe for the selected way.
    function automatic logic [1:0] way_onehot(input cache_way_t way);
        return (way == WAY1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cache_control_if.sv
// CPU, physical-memory and datapath signals seen by the cache control FSM.
// slave  : the controller (serves CPU requests, drives strobes).
// master : the surrounding cache/CPU/pmem environment.
interface cache_control_if;
    logic       mem_read;
    logic       mem_write;
    logic       mem_resp;
    logic       tag_eq0;
    logic       tag_eq1;
    logic       valid0;
    logic       valid1;
    logic       dirty0;
    logic       dirty1;
    logic       lru_out;
    logic       way_sel;
    logic [1:0] load_way;
    logic       data_src;
    logic       dirty_in;
    logic       lru_load;
    logic       lru_in;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_resp;
    logic       pmem_addr_sel;

    modport slave (
        input  mem_read, mem_write, tag_eq0, tag_eq1, valid0, valid1,
               dirty0, dirty1, lru_out, pmem_resp,
        output mem_resp, way_sel, load_way, data_src, dirty_in, lru_load,
               lru_in, pmem_read, pmem_write, pmem_addr_sel
    );

    modport master (
        output mem_read, mem_write, tag_eq0, tag_eq1, valid0, valid1,
               dirty0, dirty1, lru_out, pmem_resp,
        input  mem_resp, way_sel, load_way, data_src, dirty_in, lru_load,
               lru_in, pmem_read, pmem_write, pmem_addr_sel
    );
endinterface

// File: rtl/cache_control_sat_counter.sv
// Saturating up-counter used for hit/miss performance statistics.
// WIDTH must be at least 2.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: increment unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/cache_control.sv
// Control FSM of the 2-way set-associative L1 cache: hit detection,
// dirty-victim writeback, line allocate, plus hit/miss statistics.
module cache_control
    import cache_control_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cache_control_if.slave       bus,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);
    cache_ctrl_state_e state_q, state_d;
    cache_way_t        victim_q, victim_d;

    logic       hit0_s, hit1_s, hit_s, req_s, victim_dirty_s;
    cache_way_t hit_way_s;
    logic       mem_resp_s, way_sel_s, data_src_s, dirty_in_s;
    logic       lru_load_s, lru_in_s, pmem_read_s, pmem_write_s, pmem_addr_sel_s;
    logic [1:0] load_way_s;
    logic       hit_inc_s, miss_inc_s;

    // Way 0 wins if both comparators report a valid match.
    assign hit0_s         = bus.tag_eq0 & bus.valid0;
    assign hit1_s         = bus.tag_eq1 & bus.valid1;
    assign hit_s          = hit0_s | hit1_s;
    assign hit_way_s      = hit0_s ? WAY0 : WAY1;
    assign req_s          = bus.mem_read | bus.mem_write;
    assign victim_dirty_s = bus.lru_out ? (bus.valid1 & bus.dirty1)
                                        : (bus.valid0 & bus.dirty0);

    // Next-state and strobe decode; read+write together is handled as a write.
    always_comb begin
        state_d         = state_q;
        victim_d        = victim_q;
        mem_resp_s      = 1'b0;
        way_sel_s       = WAY0;
        load_way_s      = 2'b00;
        data_src_s      = DSRC_CPU;
        dirty_in_s      = 1'b0;
        lru_load_s      = 1'b0;
        lru_in_s        = 1'b0;
        pmem_read_s     = 1'b0;
        pmem_write_s    = 1'b0;
        pmem_addr_sel_s = 1'b0;
        hit_inc_s       = 1'b0;
        miss_inc_s      = 1'b0;
        case (state_q)
            CC_IDLE: begin
                if (req_s && hit_s) begin
                    mem_resp_s = 1'b1;
                    way_sel_s  = hit_way_s;
                    lru_load_s = 1'b1;
                    lru_in_s   = ~hit_way_s;
                    hit_inc_s  = 1'b1;
                    if (bus.mem_write) begin
                        load_way_s = way_onehot(hit_way_s);
                        data_src_s = DSRC_CPU;
                        dirty_in_s = 1'b1;
                    end else begin
                        load_way_s = 2'b00;
                    end
                end else if (req_s) begin
                    victim_d   = bus.lru_out;
                    miss_inc_s = 1'b1;
                    state_d    = victim_dirty_s ? CC_WRITEBACK : CC_ALLOCATE;
                end else begin
                    state_d = CC_IDLE;
                end
            end
            CC_WRITEBACK: begin
                pmem_write_s    = 1'b1;
                pmem_addr_sel_s = 1'b1;
                way_sel_s       = victim_q;
                if (bus.pmem_resp) begin
                    state_d = CC_ALLOCATE;
                end else begin
                    state_d = CC_WRITEBACK;
                end
            end
            CC_ALLOCATE: begin
                pmem_read_s = 1'b1;
                way_sel_s   = victim_q;
                if (bus.pmem_resp) begin
                    load_way_s = way_onehot(victim_q);
                    data_src_s = DSRC_PMEM;
                    dirty_in_s = 1'b0;
                    state_d    = CC_IDLE;
                end else begin
                    state_d = CC_ALLOCATE;
                end
            end
            default: begin
                state_d = CC_IDLE;
            end
        endcase
    end

    // Force every output low while reset is held so no strobe escapes.
    always_comb begin
        if (reset_n) begin
            bus.mem_resp      = mem_resp_s;
            bus.way_sel       = way_sel_s;
            bus.load_way      = load_way_s;
            bus.data_src      = data_src_s;
            bus.dirty_in      = dirty_in_s;
            bus.lru_load      = lru_load_s;
            bus.lru_in        = lru_in_s;
            bus.pmem_read     = pmem_read_s;
            bus.pmem_write    = pmem_write_s;
            bus.pmem_addr_sel = pmem_addr_sel_s;
        end else begin
            bus.mem_resp      = 1'b0;
            bus.way_sel       = 1'b0;
            bus.load_way      = 2'b00;
            bus.data_src      = 1'b0;
            bus.dirty_in      = 1'b0;
            bus.lru_load      = 1'b0;
            bus.lru_in        = 1'b0;
            bus.pmem_read     = 1'b0;
            bus.pmem_write    = 1'b0;
            bus.pmem_addr_sel = 1'b0;
        end
    end

    // State and victim-way registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= CC_IDLE;
            victim_q <= WAY0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (hit_inc_s),
        .count   (hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (miss_inc_s),
        .count   (miss_count)
    );
endmodule

// File: tb/tb_cache_control.sv
// Randomized scoreboard bench for cache_control. A wide-counter DUT is
// checked in full; a 2-bit-counter twin sharing the same inputs checks
// counter saturation.
module tb_cache_control;
    localparam int W_MAIN = 16;
    localparam int W_SMALL = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [W_MAIN-1:0]  hit_count, miss_count;
    logic [W_SMALL-1:0] hit_count2, miss_count2;

    cache_control_if bus ();
    cache_control_if bus2 ();

    assign bus2.mem_read  = bus.mem_read;
    assign bus2.mem_write = bus.mem_write;
    assign bus2.tag_eq0   = bus.tag_eq0;
    assign bus2.tag_eq1   = bus.tag_eq1;
    assign bus2.valid0    = bus.valid0;
    assign bus2.valid1    = bus.valid1;
    assign bus2.dirty0    = bus.dirty0;
    assign bus2.dirty1    = bus.dirty1;
    assign bus2.lru_out   = bus.lru_out;
    assign bus2.pmem_resp = bus.pmem_resp;

    cache_control #(.CNT_WIDTH(W_MAIN)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .hit_count(hit_count), .miss_count(miss_count));

    cache_control #(.CNT_WIDTH(W_SMALL)) dut_small (
        .clk(clk), .reset_n(reset_n), .bus(bus2),
        .hit_count(hit_count2), .miss_count(miss_count2));

    always #5 clk = ~clk;

    typedef struct {
        bit       resp;
        bit       ws;
        bit [1:0] lw;
        bit       ds;
        bit       di;
        bit       ll;
        bit       li;
        bit       pr;
        bit       pw;
        bit       pas;
        int       hc;
        int       mc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mdl_hits = 0;
    int   mdl_misses = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int sat(input int c, input int w);
        int m;
        m = (1 << w) - 1;
        return (c > m) ? m : c;
    endfunction

    function automatic exp_t blank();
        exp_t e;
        e = '{default: 0};
        e.hc = mdl_hits;
        e.mc = mdl_misses;
        return e;
    endfunction

    // Model: a request that hits answers this cycle on the hit way.
    task automatic push_hit(input bit way, input bit is_wr);
        exp_t e;
        e = blank();
        e.resp = 1'b1; e.ws = way; e.ll = 1'b1; e.li = ~way;
        if (is_wr) begin
            e.lw = (way ? 2'b10 : 2'b01); e.ds = 1'b0; e.di = 1'b1;
        end
        exp_q.push_back(e);
        mdl_hits++;
    endtask

    task automatic push_wb(input bit vic);
        exp_t e;
        e = blank();
        e.ws = vic; e.pw = 1'b1; e.pas = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic push_alloc(input bit vic, input bit last);
        exp_t e;
        e = blank();
        e.ws = vic; e.pr = 1'b1;
        if (last) begin
            e.lw = (vic ? 2'b10 : 2'b01); e.ds = 1'b1; e.di = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: any strobe activity is one expected event, checked in order.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (bus.mem_resp || bus.lru_load || (bus.load_way != 2'b00) ||
                        bus.pmem_read || bus.pmem_write)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {bus.mem_resp, bus.pmem_read, bus.pmem_write}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("mem_resp",   bus.mem_resp, e.resp);
                chk("way_sel",    bus.way_sel, e.ws);
                chk("load_way",   bus.load_way, e.lw);
                chk("lru_load",   bus.lru_load, e.ll);
                if (e.ll) chk("lru_in", bus.lru_in, e.li);
                if (e.lw != 2'b00) begin
                    chk("data_src", bus.data_src, e.ds);
                    chk("dirty_in", bus.dirty_in, e.di);
                end
                chk("pmem_read",     bus.pmem_read, e.pr);
                chk("pmem_write",    bus.pmem_write, e.pw);
                chk("pmem_addr_sel", bus.pmem_addr_sel, e.pas);
                chk("hit_count",     hit_count, sat(e.hc, W_MAIN));
                chk("miss_count",    miss_count, sat(e.mc, W_MAIN));
                chk("hit_count_w2",  hit_count2, sat(e.hc, W_SMALL));
                chk("miss_count_w2", miss_count2, sat(e.mc, W_SMALL));
            end
        end
    end

    task automatic clear_inputs();
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.tag_eq0 = 1'b0; bus.tag_eq1 = 1'b0;
        bus.valid0 = 1'b0; bus.valid1 = 1'b0;
        bus.dirty0 = 1'b0; bus.dirty1 = 1'b0;
        bus.lru_out = 1'b0; bus.pmem_resp = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {bus.mem_resp, bus.way_sel, bus.load_way, bus.data_src, bus.dirty_in,
                 bus.lru_load, bus.lru_in, bus.pmem_read, bus.pmem_write,
                 bus.pmem_addr_sel}, 32'd0);
        chk({nm, "_cnt"}, {hit_count, miss_count, hit_count2, miss_count2}, 32'd0);
    endtask

    // One CPU transaction; the model decides hit/clean miss/dirty miss.
    task automatic do_txn(input bit rd, input bit wr, input bit te0, input bit te1,
                          input bit v0, input bit v1, input bit d0, input bit d1,
                          input bit lru, input int wl, input int rl);
        bit h0, h1, vic;
        bit [1:0] vv, dd;
        h0 = te0 & v0; h1 = te1 & v1;
        vv = {v1, v0}; dd = {d1, d0}; vic = lru;
        @(posedge clk); #1;
        bus.mem_read = rd; bus.mem_write = wr;
        bus.tag_eq0 = te0; bus.tag_eq1 = te1;
        bus.valid0 = v0; bus.valid1 = v1;
        bus.dirty0 = d0; bus.dirty1 = d1;
        bus.lru_out = lru; bus.pmem_resp = 1'b0;
        if (h0 || h1) begin
            push_hit(h0 ? 1'b0 : 1'b1, wr);
            @(posedge clk); #1;
        end else begin
            mdl_misses++;
            @(posedge clk); #1;
            if (vv[vic] && dd[vic]) begin
                for (int k = 1; k <= wl; k++) begin
                    push_wb(vic);
                    bus.pmem_resp = (k == wl);
                    @(posedge clk); #1;
                end
            end
            for (int k = 1; k <= rl; k++) begin
                push_alloc(vic, k == rl);
                bus.pmem_resp = (k == rl);
                @(posedge clk); #1;
            end
            bus.pmem_resp = 1'b0;
            if (vic) begin
                bus.tag_eq1 = 1'b1; bus.valid1 = 1'b1; bus.dirty1 = 1'b0;
            end else begin
                bus.tag_eq0 = 1'b1; bus.valid0 = 1'b1; bus.dirty0 = 1'b0;
            end
            push_hit(vic, wr);
            @(posedge clk); #1;
        end
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int op, gaps;
        bit rd, wr;
        clear_inputs();
        reset_n = 1'b0;
        #12;
        chk_all_zero("reset_outputs");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Directed: read hit way 1, write hit way 0, clean miss, dirty miss.
        do_txn(1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1);
        do_txn(0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 1);
        do_txn(1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 3);
        do_txn(1, 0, 0, 0, 1, 1, 1, 0, 0, 2, 2);
        do_txn(1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1);

        // Random traffic with stray pmem_resp pulses while idle.
        for (int t = 0; t < 200; t++) begin
            op = $urandom_range(2, 0);
            rd = (op != 1); wr = (op != 0);
            do_txn(rd, wr, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(3, 1), $urandom_range(3, 1));
            gaps = $urandom_range(2, 0);
            for (int g = 0; g < gaps; g++) begin
                bus.pmem_resp = 1'($urandom);
                @(posedge clk); #1;
            end
            bus.pmem_resp = 1'b0;
        end

        // Reset asserted in the middle of an allocate.
        @(posedge clk); #1;
        clear_inputs();
        bus.mem_read = 1'b1; bus.lru_out = 1'b1;
        mdl_misses++;
        @(posedge clk); #1;
        push_alloc(1'b1, 1'b0);
        @(posedge clk); #1;
        chk("alloc_pmem_read_before_reset", bus.pmem_read, 1'b1);
        bus.tag_eq0 = 1'b1; bus.valid0 = 1'b1;
        reset_n = 1'b0;
        #1;
        chk_all_zero("mid_alloc_reset");
        @(posedge clk); #1;
        chk_all_zero("reset_held_with_hit_inputs");
        clear_inputs();
        mdl_hits = 0; mdl_misses = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_all_zero("idle_after_reset");
        end

        // Five back-to-back hits: 2-bit counter must stick at 3.
        for (int h = 0; h < 5; h++) begin
            do_txn(1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1);
        end
        @(negedge clk);
        chk("sat_hit_count_w2", hit_count2, 32'd3);
        chk("hit_count_after_5", hit_count, 32'd5);

        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- Control FSM of the 2-way set-associative L1 cache. It sits directly downstream of the two per-way tag comparators and consumes their equal outputs.
- Combines the comparator outputs with the valid, dirty and LRU bits from the datapath arrays, then decides hit, writeback or allocate.
- Drives the datapath load/select strobes, the CPU handshake (mem_resp) and the physical-memory handshake (pmem_read/pmem_write).
- Keeps saturating hit and miss counters for performance debug.

Parameters:
- CNT_WIDTH, 16, width of the hit_count and miss_count performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  CPU read request, held until mem_resp.
- mem_write  in  1  CPU write request, held until mem_resp.
- mem_resp  out  1  CPU request complete, one-cycle pulse.
- tag_eq0  in  1  way-0 comparator output: 1 means equal.
- tag_eq1  in  1  way-1 comparator output.
- valid0  in  1  valid bit, way 0, indexed set.
- valid1  in  1  valid bit, way 1.
- dirty0  in  1  dirty bit, way 0.
- dirty1  in  1  dirty bit, way 1.
- lru_out  in  1  least-recently-used way of the indexed set.
- way_sel  out  1  way driving the data-out and victim muxes.
- load_way  out  2  one-hot write strobe for the data/tag/valid/dirty arrays of a way.
- data_src  out  1  data source: 0 = CPU write merge, 1 = pmem line.
- dirty_in  out  1  dirty value written with load_way.
- lru_load  out  1  LRU array write enable.
- lru_in  out  1  new LRU value.
- pmem_read  out  1  physical memory read request.
- pmem_write  out  1  physical memory write request.
- pmem_resp  in  1  physical memory done, one-cycle pulse.
- pmem_addr_sel  out  1  pmem address source: 0 = CPU address, 1 = victim tag + set.
- hit_count  out  CNT_WIDTH  saturating hit counter.
- miss_count  out  CNT_WIDTH  saturating miss counter.

Behaviour:
- Reset (async, reset_n=0):
  - state goes to IDLE and victim register clears to 0.
  - Counters reset to 0.
  - All outputs are 0 while reset is asserted, including pmem_read and pmem_write, which drop immediately mid-transaction.
- Hit detection:
  - hit0 = tag_eq0 & valid0; hit1 = tag_eq1 & valid1.
  - If both are set (illegal), way 0 wins.
  - If mem_read and mem_write are both high (illegal), the request is treated as a write.
- IDLE, request present, hit:
  - mem_resp=1 in the same cycle (zero-wait hit).
  - way_sel = hit way; lru_load=1; lru_in = ~hit way.
  - Write hit: load_way[hit way]=1, data_src=0, dirty_in=1.
  - hit_count increments at the clock edge.
  - State stays IDLE.
- IDLE, request present, miss:
  - victim register <= lru_out; miss_count increments.
  - Next state is WRITEBACK if the victim way is valid and dirty, else ALLOCATE.
  - mem_resp=0.
- WRITEBACK:
  - pmem_write=1, pmem_addr_sel=1, way_sel=victim.
  - Stays until pmem_resp, then goes to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_addr_sel=0, way_sel=victim.
  - On the pmem_resp cycle: load_way[victim]=1, data_src=1, dirty_in=0; the tag and valid=1 are loaded by the same strobe.
  - Next state is IDLE.
- Return to IDLE after a miss:
  - The request is re-evaluated and hits, so mem_resp comes 1 cycle after the allocate pmem_resp.
  - A write miss therefore completes as a write hit.
- Latency:
  - Hit: 0 extra cycles.
  - Clean miss: pmem read latency + 1.
  - Dirty miss: write latency + read latency + 1.
- Request dropped mid-miss: the outstanding pmem transaction completes and the line is still filled; no mem_resp is issued.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.
- Counters saturate at all-ones and never wrap. A miss counts once; the later refill hit also increments hit_count.
- Strobe outputs (load_way, lru_load, mem_resp, pmem_*) are combinational from state and inputs. No output glitches into a strobe during reset.

Decomposition:
- Add to cache_types:
  - enum cache_ctrl_state {CC_IDLE, CC_WRITEBACK, CC_ALLOCATE}.
  - typedef cache_way (1 bit).
  - constants WAY0=0, WAY1=1.
  - constants DSRC_CPU=0, DSRC_PMEM=1.
- Sub-module sat_counter (parameter WIDTH; inputs clk, reset_n, inc; output count), instantiated twice for hit_count and miss_count.

Test Plan:
- Read hit on way 1 (tag_eq1=1, valid1=1, mem_read=1) -> mem_resp=1 same cycle, lru_load=1, lru_in=0, load_way=00, hit_count=1.
- Write hit on way 0 -> load_way=01, data_src=0, dirty_in=1, lru_in=1, mem_resp=1 same cycle.
- Clean read miss, lru_out=1, valid1=0, pmem_resp after 3 cycles -> pmem_read high cycles 1-3, pmem_addr_sel=0, load_way=10 with data_src=1 and dirty_in=0 on cycle 3; after the bench sets tag_eq1=valid1=1, mem_resp on cycle 4; miss_count=1.
- Dirty miss, lru_out=0, valid0=dirty0=1, write latency 2, read latency 2 -> pmem_write=1 with pmem_addr_sel=1 and way_sel=0 for 2 cycles, then pmem_read for 2 cycles, load_way=01, mem_resp 1 cycle later.
- reset_n pulled low during ALLOCATE -> pmem_read=0 immediately, state IDLE, counters 0; after release, an idle bus keeps all outputs 0.
- Counter saturation with CNT_WIDTH=2: 5 consecutive hits -> hit_count sequence 1,2,3,3,3.
